// File: rtl/pcm_out_writer.sv
// Producer side of the stereo PCM ring: writes handshaked sample pairs at a
// free-running pointer, throttled by the playback read address.
module pcm_out_writer #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 16,
    parameter int GRANULE_LEN   = 576
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_ch0,
    input  logic [DATA_WIDTH-1:0]    in_ch1,
    input  logic                     in_last,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_d_ch0,
    output logic [DATA_WIDTH-1:0]    wr_d_ch1,
    output logic [ADDRESS_WIDTH-1:0] fill,
    output logic                     gr_done,
    output logic                     underrun,
    output logic                     len_err
);

    localparam logic [ADDRESS_WIDTH-1:0] CNT_LAST = ADDRESS_WIDTH'(GRANULE_LEN - 1);
    // Playback starts one granule behind the writer (pre-roll).
    localparam logic [ADDRESS_WIDTH-1:0] RD_INIT  = ADDRESS_WIDTH'((2 ** ADDRESS_WIDTH) - GRANULE_LEN);

    typedef enum logic [1:0] {ST_RUN, ST_FULL, ST_DONE} st_t;

    st_t                     st_q, st_d;
    logic [ADDRESS_WIDTH-1:0] wp_q, wp_d;
    logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] rd_q, rd_d;
    logic                     empty_q, empty_d;
    logic                     wr_en_q, wr_en_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]    wr_d_ch0_q, wr_d_ch0_d;
    logic [DATA_WIDTH-1:0]    wr_d_ch1_q, wr_d_ch1_d;
    logic                     gr_done_q, gr_done_d;
    logic                     underrun_q, underrun_d;
    logic                     len_err_q, len_err_d;

    logic [ADDRESS_WIDTH-1:0] fill_w;
    logic                     full_w;
    logic                     empty_w;
    logic                     xfer_w;

    assign fill_w   = wp_q - rd_addr;
    assign full_w   = (fill_w == '1);
    assign empty_w  = (fill_w == '0);
    assign in_ready = (st_q == ST_RUN) && !full_w;
    assign xfer_w   = in_valid && in_ready;

    always_comb begin
        st_d       = st_q;
        wp_d       = wp_q;
        cnt_d      = cnt_q;
        rd_d       = rd_addr;
        empty_d    = empty_w;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_d_ch0_d = wr_d_ch0_q;
        wr_d_ch1_d = wr_d_ch1_q;
        gr_done_d  = 1'b0;
        len_err_d  = len_err_q;
        // Playback moved on while the previous cycle saw an empty ring.
        underrun_d = underrun_q | ((rd_addr != rd_q) && empty_q);

        case (st_q)
            ST_RUN: begin
                if (xfer_w) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = wp_q;
                    wr_d_ch0_d = in_ch0;
                    wr_d_ch1_d = in_ch1;
                    wp_d       = wp_q + ADDRESS_WIDTH'(1);
                    if (in_last) begin
                        cnt_d = '0;
                        st_d  = ST_DONE;
                        if (cnt_q != CNT_LAST) begin
                            len_err_d = 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        len_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ADDRESS_WIDTH'(1);
                    end
                end else if (full_w && in_valid) begin
                    st_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!full_w) begin
                    st_d = ST_RUN;
                end
            end
            ST_DONE: begin
                gr_done_d = 1'b1;
                st_d      = ST_RUN;
            end
            default: st_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= ST_RUN;
            wp_q       <= '0;
            cnt_q      <= '0;
            rd_q       <= RD_INIT;
            empty_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_d_ch0_q <= '0;
            wr_d_ch1_q <= '0;
            gr_done_q  <= 1'b0;
            underrun_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            st_q       <= st_d;
            wp_q       <= wp_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            empty_q    <= empty_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_d_ch0_q <= wr_d_ch0_d;
            wr_d_ch1_q <= wr_d_ch1_d;
            gr_done_q  <= gr_done_d;
            underrun_q <= underrun_d;
            len_err_q  <= len_err_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_d_ch0 = wr_d_ch0_q;
    assign wr_d_ch1 = wr_d_ch1_q;
    assign fill     = fill_w;
    assign gr_done  = gr_done_q;
    assign underrun = underrun_q;
    assign len_err  = len_err_q;

endmodule

// File: doc/pcm_out_writer.md
# pcm_out_writer

Producer side of the stereo PCM output buffer. Accepts decoded sample pairs from the synthesis filterbank over a valid/ready handshake and writes them into the two channel RAMs at a free-running ring pointer. Flow control against the playback read address keeps samples from being overwritten before playback reads them. Also reports fill level, playback underrun and granule-length errors.

## Interface
Parameters (from `defines.v`):
- `ADDRESS_WIDTH`, 10: RAM address width; ring depth is 1024.
- `DATA_WIDTH`, 16: PCM sample width per channel.
- `GRANULE_LEN`, 576: sample pairs per granule.

Ports:
- `clk` in 1: single system clock; all logic rises on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: a sample pair is presented.
- `in_ready` out 1: the writer can accept a pair this cycle.
- `in_ch0` in `DATA_WIDTH`: left sample.
- `in_ch1` in `DATA_WIDTH`: right sample.
- `in_last` in 1: marks the final pair of a granule; qualified by handshake.
- `rd_addr` in `ADDRESS_WIDTH`: current playback read address.
- `wr_en` out 1: write strobe to both channel RAMs.
- `wr_addr` out `ADDRESS_WIDTH`: write address.
- `wr_d_ch0` out `DATA_WIDTH`: write data, channel 0 RAM.
- `wr_d_ch1` out `DATA_WIDTH`: write data, channel 1 RAM.
- `fill` out `ADDRESS_WIDTH`: occupied entries, `(wp - rd_addr) mod 1024`.
- `gr_done` out 1: one-cycle pulse after the last write of a granule.
- `underrun` out 1: sticky; playback advanced while the buffer was empty.
- `len_err` out 1: sticky; a granule closed with the wrong pair count.

## Operation
- Internal write pointer `wp` resets to 0. Playback read address resets to 448, so the initial `fill` is 576: one granule of pre-roll, ring content don't-care.
- Arithmetic:
  - `fill = wp - rd_addr`, truncated to 10 bits, wrapping naturally.
  - `full = (fill == 1023)`.
  - `empty = (fill == 0)`.
- Handshake: a transfer occurs when `in_valid && in_ready`. Data and `in_last` are sampled on that edge. `in_valid` may toggle freely; the writer does not require it to be held.
- State machine `st`:
  - RUN: `in_ready = !full`.
    - On a transfer: register the pair into `wr_d_*`, set `wr_addr <= wp`, `wr_en <= 1`, `wp <= wp+1` (wraps 1023→0), `cnt <= cnt+1`.
    - On a transfer with `in_last`: go to DONE.
  - FULL: entered from RUN when `full` and `in_valid`. `in_ready = 0`. Return to RUN on the first cycle where `full` deasserts.
  - DONE: single cycle, `in_ready = 0`. Pulse `gr_done`, then return to RUN.
- Granule counter `cnt` (10 bits):
  - Resets to 0 and clears to 0 on every `in_last` transfer.
  - Set `len_err` if `in_last` arrives with `cnt != GRANULE_LEN-1`.
  - Set `len_err` if `cnt` reaches `GRANULE_LEN-1` on a transfer without `in_last`. In that case `cnt` wraps to 0 and the writer stays in RUN.
- Underrun:
  - The registered copy `rd_q` is taken every clk.
  - If `rd_addr != rd_q` and the previous cycle's `fill` was 0, set `underrun`.
  - The writer does not realign the pointer; playback wraps and replays stale data.
- Sticky flags clear only on reset.
- Simultaneous write and read advance in the same cycle: `fill` is unchanged. `full` is re-evaluated from the new `wp` and `rd_addr` each cycle.

## Timing
- Reset values:
  - `in_ready = 1`, `wr_en = 0`, `wr_addr = 0`, `wr_d_ch0/1 = 0`.
  - `fill = 576` (combinational from `wp = 0`, `rd_addr = 448`).
  - `gr_done = 0`, `underrun = 0`, `len_err = 0`, `st = RUN`, `cnt = 0`.
- `wr_en`, `wr_addr` and `wr_d_*` are valid one cycle after the handshake edge and last exactly one cycle per transfer.
- `fill` reflects `wp` after the increment, i.e. the same cycle `wr_en` is high.
- `in_ready` deasserts combinationally in the cycle `fill` reaches 1023, so the 1024th entry is never written.
- Throughput: one pair per clk in RUN; one bubble cycle (DONE) per granule.
- `gr_done` is high in the cycle after the `wr_en` of the last pair.
- Reset mid-granule: all state returns to reset values immediately and asynchronously. An in-flight `wr_en` is dropped.

## Test plan
- Reset release with `rd_addr=448` held → `fill=576`, `in_ready=1`, `wr_en=0`. The first transfer writes `wr_addr=0` one cycle later.
- 576 back-to-back pairs with `in_last` on the final pair, `rd_addr` static → `wr_addr` 0..575, then `gr_done` one cycle after the last write. `in_ready=0` for exactly one cycle (DONE). `len_err=0`.
- `rd_addr` static at 448, stream continuously → `wp` stops at 447 with `fill=1023`, `in_ready=0`. Incrementing `rd_addr` to 449 → exactly one more write at `wr_addr=447`.
- `in_last` on the 100th pair → `len_err=1`, `gr_done` pulses, `cnt` restarts at 0 for the next granule.
- Drain: set `rd_addr` to equal `wp` (`fill=0`), then advance `rd_addr` by 1 → `underrun` sets and stays set until `rst_n` low.
- Write wrap plus simultaneous read: `wp` at 1023 with `rd_addr` advancing in the same cycle as a transfer → write at 1023, `wp` wraps to 0, `fill` unchanged.
- Assert `rst_n` low during a transfer → `wr_en` clears immediately and all outputs return to reset values.
